easyaxi_resp_sched: RTL and testbench

Slave-side response scheduler: the responder-end counterpart of the master-side per-ID ordering tracker. It records each accepted request's slot pointer in a per-ID queue, marks slots complete as the backend finishes them out of order, and grants one completed burst at a time to the response channel. Per-ID order is always preserved; different IDs may be returned out of order. It sits between the slave's AR/AW acceptance logic, its storage/backend, and the R/B output channel.

---
 rtl/easyaxi_resp_sched.sv | 191 +++++++++++++++++++
 tb/tb_easyaxi_resp_sched.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/easyaxi_resp_sched.sv
// easyaxi_resp_sched
//   Slave-side response scheduler. Every accepted request parks its slot
//   pointer in a per-ID FIFO. The backend marks slots done in any order, and
//   one completed burst at a time is granted to the R/B channel. Order within
//   an ID is preserved; different IDs may overtake each other.
//
// Build option:
//   EASYAXI_RESP_SCHED_RR_EN  defined   : round-robin among eligible IDs
//                             undefined : fixed priority, lowest ID wins
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (req_id, req_ptr)
//   done_valid, done_ptr       backend finished filling slot done_ptr
//   resp_valid/resp_ready      response handshake (resp_id, resp_ptr held)
//   resp_last                  final beat of the granted burst
//   idle                       no queued request and no grant held
module easyaxi_resp_sched #(
  parameter  int OST_DEPTH = 16,
  parameter  int ID_WIDTH  = 4,
  localparam int PTR_WIDTH = $clog2(OST_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ID_WIDTH-1:0]  req_id,
  input  logic [PTR_WIDTH-1:0] req_ptr,
  input  logic                 done_valid,
  input  logic [PTR_WIDTH-1:0] done_ptr,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_WIDTH-1:0]  resp_id,
  output logic [PTR_WIDTH-1:0] resp_ptr,
  input  logic                 resp_last,
  output logic                 idle
);

  localparam int ID_NUM    = 1 << ID_WIDTH;
  localparam int CNT_WIDTH = PTR_WIDTH + 1;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t                 state_r;
  logic                   resp_valid_r;
  logic [ID_WIDTH-1:0]    resp_id_r;
  logic [PTR_WIDTH-1:0]   resp_ptr_r;

  logic [PTR_WIDTH-1:0]   fifo_mem_r [ID_NUM][OST_DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr_r   [ID_NUM];
  logic [PTR_WIDTH-1:0]   rd_ptr_r   [ID_NUM];
  logic [CNT_WIDTH-1:0]   cnt_r      [ID_NUM];
  logic [OST_DEPTH-1:0]   done_r;

  logic [PTR_WIDTH-1:0]   head_s     [ID_NUM];
  logic [ID_NUM-1:0]      full_s;
  logic [ID_NUM-1:0]      empty_s;
  logic [ID_NUM-1:0]      elig_s;
  logic [ID_NUM-1:0]      push_vec_s;
  logic [ID_NUM-1:0]      pop_vec_s;
  logic                   push_s;
  logic                   pop_s;
  logic [OST_DEPTH-1:0]   done_set_s;
  logic [OST_DEPTH-1:0]   done_clr_s;
  logic                   grant_found_s;
  logic [ID_WIDTH-1:0]    grant_id_s;
  logic [ID_WIDTH-1:0]    scan_id_s;
`ifdef EASYAXI_RESP_SCHED_RR_EN
  logic [ID_WIDTH-1:0]    rr_ptr_r;
`endif

  assign req_ready  = ~full_s[req_id];
  assign push_s     = req_valid && req_ready;
  // resp_valid_r is only ever high in BUSY, so this is the completing beat.
  assign pop_s      = resp_valid_r && resp_ready && resp_last;
  assign done_set_s = done_valid ? (OST_DEPTH'(1'b1) << done_ptr) : {OST_DEPTH{1'b0}};
  assign done_clr_s = pop_s ? (OST_DEPTH'(1'b1) << resp_ptr_r) : {OST_DEPTH{1'b0}};

  assign resp_valid = resp_valid_r;
  assign resp_id    = resp_id_r;
  assign resp_ptr   = resp_ptr_r;
  assign idle       = (&empty_s) && (state_r == ST_IDLE);

  // Per-queue head, occupancy flags, eligibility and push/pop decode.
  always_comb begin
    for (int i = 0; i < ID_NUM; i++) begin
      head_s[i]     = fifo_mem_r[i][rd_ptr_r[i]];
      full_s[i]     = (cnt_r[i] == CNT_WIDTH'(OST_DEPTH));
      empty_s[i]    = (cnt_r[i] == CNT_WIDTH'(0));
      elig_s[i]     = !empty_s[i] && done_r[head_s[i]];
      push_vec_s[i] = push_s && (req_id == ID_WIDTH'(i));
      pop_vec_s[i]  = pop_s && (resp_id_r == ID_WIDTH'(i));
    end
  end

  // Pick the winning eligible ID: scan starts at the RR pointer or at ID 0.
  always_comb begin
    grant_found_s = 1'b0;
    grant_id_s    = {ID_WIDTH{1'b0}};
    scan_id_s     = {ID_WIDTH{1'b0}};
    for (int k = 0; k < ID_NUM; k++) begin
`ifdef EASYAXI_RESP_SCHED_RR_EN
      scan_id_s = rr_ptr_r + ID_WIDTH'(k);
`else
      scan_id_s = ID_WIDTH'(k);
`endif
      if (!grant_found_s && elig_s[scan_id_s]) begin
        grant_found_s = 1'b1;
        grant_id_s    = scan_id_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Grant FSM: registers the winner on IDLE->BUSY, releases on the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      resp_valid_r <= 1'b0;
      resp_id_r    <= {ID_WIDTH{1'b0}};
      resp_ptr_r   <= {PTR_WIDTH{1'b0}};
`ifdef EASYAXI_RESP_SCHED_RR_EN
      rr_ptr_r     <= {ID_WIDTH{1'b0}};
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_found_s) begin
            state_r      <= ST_BUSY;
            resp_valid_r <= 1'b1;
            resp_id_r    <= grant_id_s;
            resp_ptr_r   <= head_s[grant_id_s];
`ifdef EASYAXI_RESP_SCHED_RR_EN
            rr_ptr_r     <= grant_id_s + ID_WIDTH'(1);
`endif
          end
        end
        ST_BUSY: begin
          if (pop_s) begin
            state_r      <= ST_IDLE;
            resp_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          resp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Per-ID pointer FIFOs; simultaneous push and pop leave occupancy unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ID_NUM; i++) begin
        wr_ptr_r[i] <= {PTR_WIDTH{1'b0}};
        rd_ptr_r[i] <= {PTR_WIDTH{1'b0}};
        cnt_r[i]    <= {CNT_WIDTH{1'b0}};
        for (int j = 0; j < OST_DEPTH; j++) begin
          fifo_mem_r[i][j] <= {PTR_WIDTH{1'b0}};
        end
      end
    end else begin
      for (int i = 0; i < ID_NUM; i++) begin
        if (push_vec_s[i]) begin
          fifo_mem_r[i][wr_ptr_r[i]] <= req_ptr;
          wr_ptr_r[i]                <= wr_ptr_r[i] + PTR_WIDTH'(1);
        end
        if (pop_vec_s[i]) begin
          rd_ptr_r[i] <= rd_ptr_r[i] + PTR_WIDTH'(1);
        end
        case ({push_vec_s[i], pop_vec_s[i]})
          2'b10:   cnt_r[i] <= cnt_r[i] + CNT_WIDTH'(1);
          2'b01:   cnt_r[i] <= cnt_r[i] - CNT_WIDTH'(1);
          default: cnt_r[i] <= cnt_r[i];
        endcase
      end
    end
  end

  // Slot completion bitmap; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r <= {OST_DEPTH{1'b0}};
    end else begin
      done_r <= (done_r & ~done_clr_s) | done_set_s;
    end
  end

endmodule

// File: tb/tb_easyaxi_resp_sched.sv
module tb_easyaxi_resp_sched;

  localparam int NID  = 4;
  localparam int NOST = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_id = 2'd0;
  logic [1:0] req_ptr = 2'd0;
  logic       done_valid = 1'b0;
  logic [1:0] done_ptr = 2'd0;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic [1:0] resp_id;
  logic [1:0] resp_ptr;
  logic       resp_last = 1'b0;
  logic       idle;

  easyaxi_resp_sched #(.OST_DEPTH(NOST), .ID_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id), .req_ptr(req_ptr),
    .done_valid(done_valid), .done_ptr(done_ptr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_ptr(resp_ptr), .resp_last(resp_last), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {int id; int ptr;} grant_t;

  // Reference model state: per-ID queues of slot numbers, a done flag per
  // slot, and whether a burst is currently granted.
  int     mq [NID][$];
  bit     m_done [NOST];
  int     slot_state [NOST];   // 0 free, 1 queued not done, 2 done
  bit     m_busy;
  int     m_gid, m_gptr, m_rr;
  grant_t exp_q [$];
  int     grant_log [$];
  int     n_tests = 0;
  int     n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NID; i++) mq[i].delete();
    for (int s = 0; s < NOST; s++) begin
      m_done[s] = 1'b0;
      slot_state[s] = 0;
    end
    m_busy = 1'b0; m_gid = 0; m_gptr = 0; m_rr = 0;
    exp_q.delete();
  endtask

  function automatic bit model_idle();
    bit e = 1'b1;
    for (int i = 0; i < NID; i++) if (mq[i].size() != 0) e = 1'b0;
    return e && !m_busy;
  endfunction

  // One clock of the reference: decisions use the state before the edge.
  task automatic model_step();
    int  rid    = int'(req_id);
    bit  accept = req_valid && (mq[rid].size() < NOST);
    bit  hs     = m_busy && resp_ready && resp_last;
    int  win    = -1;
    int  start;
`ifdef EASYAXI_RESP_SCHED_RR_EN
    start = m_rr;
`else
    start = 0;
`endif
    if (!m_busy) begin
      for (int k = 0; k < NID; k++) begin
        int id = (start + k) % NID;
        if (win < 0 && mq[id].size() > 0 && m_done[mq[id][0]]) win = id;
      end
    end
    if (win >= 0) begin
      m_busy = 1'b1;
      m_gid  = win;
      m_gptr = mq[win][0];
      m_rr   = (win + 1) % NID;
      exp_q.push_back('{win, m_gptr});
    end else if (hs) begin
      void'(mq[m_gid].pop_front());
      m_done[m_gptr]     = 1'b0;
      slot_state[m_gptr] = 0;
      m_busy             = 1'b0;
    end
    if (done_valid) begin
      m_done[int'(done_ptr)]     = 1'b1;
      slot_state[int'(done_ptr)] = 2;
    end
    if (accept) begin
      mq[rid].push_back(int'(req_ptr));
      slot_state[int'(req_ptr)] = 1;
    end
  endtask

  task automatic model_loop();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_clear();
      else        model_step();
    end
  endtask

  // Monitor: pops an expected grant whenever the DUT raises resp_valid and
  // checks handshake-visible outputs against the reference every cycle.
  task automatic monitor_loop();
    bit     prev_v = 1'b0;
    grant_t cur = '{0, 0};
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (resp_valid && !prev_v) begin
          check("grant_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) cur = exp_q.pop_front();
          grant_log.push_back(int'(resp_id));
        end
        if (resp_valid) begin
          check("resp_id", int'(resp_id), cur.id);
          check("resp_ptr", int'(resp_ptr), cur.ptr);
        end
        check("resp_valid", int'(resp_valid), int'(m_busy));
        check("req_ready", int'(req_ready), int'(mq[int'(req_id)].size() < NOST));
        check("idle", int'(idle), int'(model_idle()));
      end
      prev_v = resp_valid;
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send_req(input int id, input int ptr);
    req_valid = 1'b1; req_id = id[1:0]; req_ptr = ptr[1:0];
    step();
    req_valid = 1'b0;
  endtask

  task automatic send_done(input int ptr);
    done_valid = 1'b1; done_ptr = ptr[1:0];
    step();
    done_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    bit seen = resp_valid;
    for (int c = 0; c < 50 && !seen; c++) begin
      step();
      seen = resp_valid;
    end
    check(name, int'(seen), 1);
  endtask

  // Completes every outstanding slot and lets all bursts drain.
  task automatic drain();
    bit quiet = 1'b0;
    req_valid = 1'b0; resp_ready = 1'b1; resp_last = 1'b1;
    for (int c = 0; c < 200 && !quiet; c++) begin
      done_valid = 1'b0;
      for (int s = 0; s < NOST; s++) begin
        if (!done_valid && slot_state[s] == 1) begin
          done_valid = 1'b1; done_ptr = s[1:0];
        end
      end
      step();
      quiet = idle && !done_valid;
    end
    done_valid = 1'b0;
    check("drain_idle", int'(idle), 1);
  endtask

  task automatic random_cycle();
    int pool [$];
    req_valid = 1'b0; done_valid = 1'b0;
    if ($urandom_range(0, 2) == 0) begin
      for (int s = 0; s < NOST; s++) if (slot_state[s] == 0) pool.push_back(s);
      if (pool.size() > 0) begin
        req_valid = 1'b1;
        req_id    = 2'($urandom_range(0, 3));
        req_ptr   = 2'(pool[$urandom_range(0, pool.size() - 1)]);
      end
    end
    pool.delete();
    if ($urandom_range(0, 2) == 0) begin
      for (int s = 0; s < NOST; s++) if (slot_state[s] == 1) pool.push_back(s);
      if (pool.size() > 0) begin
        done_valid = 1'b1;
        done_ptr   = 2'(pool[$urandom_range(0, pool.size() - 1)]);
      end
    end
    resp_ready = ($urandom_range(0, 3) != 0);
    resp_last  = ($urandom_range(0, 2) == 0);
    step();
  endtask

  initial begin
    bit pat [5];
    int exp_ord [4];
    int base;
    fork
      model_loop();
      monitor_loop();
    join_none

    repeat (3) step();
    rst_n = 1'b1;
    #1;
    check("rst_resp_valid", int'(resp_valid), 0);
    check("rst_resp_id", int'(resp_id), 0);
    check("rst_resp_ptr", int'(resp_ptr), 0);
    check("rst_idle", int'(idle), 1);
    check("rst_req_ready", int'(req_ready), 1);
    step();

    // Same-ID order: (1,2) must be granted before (1,0) although 0 is done first.
    resp_ready = 1'b1; resp_last = 1'b1;
    send_req(1, 2); send_req(1, 0); send_done(0);
    repeat (4) step();
    send_done(2);
    drain();

    // Cross-ID reorder: id3 overtakes id0 whose slot is not yet done.
    send_req(0, 1); send_req(3, 2); send_done(2);
    repeat (4) step();
    drain();

    // Multi-beat hold with ready pattern 1,0,1,1,1 and last on beat 4.
    resp_ready = 1'b0; resp_last = 1'b0;
    send_req(0, 3); send_done(3);
    wait_valid("s3_grant");
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 5; k++) begin
      resp_ready = pat[k];
      resp_last  = (k == 4);
      step();
    end
    resp_ready = 1'b0; resp_last = 1'b0;
    check("s3_valid_drop", int'(resp_valid), 0);
    drain();

    // Full queue: id2 holds four requests, id0 still accepts.
    resp_ready = 1'b0;
    for (int p = 0; p < 4; p++) send_req(2, p);
    req_id = 2'd2; #1;
    check("s4_full_id2", int'(req_ready), 0);
    req_id = 2'd0; #1;
    check("s4_ready_id0", int'(req_ready), 1);
    req_id = 2'd2;
    send_done(0);
    resp_ready = 1'b1; resp_last = 1'b1;
    wait_valid("s4_grant");
    step(); #1;
    check("s4_ready_after_pop", int'(req_ready), 1);
    drain();

    // Reset while a burst is held: resp_valid must fall without a clock.
    resp_ready = 1'b0; resp_last = 1'b0;
    send_req(1, 1); send_done(1);
    wait_valid("s6_grant");
    #2 rst_n = 1'b0;
    #1 check("s6_async_clear", int'(resp_valid), 0);
    step(); step();
    rst_n = 1'b1;
    #1;
    check("s6_idle", int'(idle), 1);
    check("s6_req_ready", int'(req_ready), 1);
    step();

    // Arbitration order across ids 0,1,2 (pointer freshly reset).
    resp_ready = 1'b0; resp_last = 1'b1;
    base = grant_log.size();
    send_req(0, 0); send_req(1, 1); send_req(2, 2); send_req(0, 3);
    for (int p = 0; p < 4; p++) send_done(p);
    drain();
`ifdef EASYAXI_RESP_SCHED_RR_EN
    exp_ord = '{0, 1, 2, 0};
`else
    exp_ord = '{0, 0, 1, 2};
`endif
    for (int k = 0; k < 4; k++) begin
      check("arb_order", (grant_log.size() > base + k) ? grant_log[base + k] : -1, exp_ord[k]);
    end

    // Randomized traffic checked by the monitor against the reference.
    repeat (3000) random_cycle();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
